im_loader: RTL

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// im_loader: streams a length-prefixed, big-endian byte frame from a host into
// instruction memory while holding the processor in reset.
// Optional feature: define IM_LOADER_CHECKSUM_EN to append an XOR checksum
// byte to every frame (CHK state); undefined, the last write goes to DONE.
module im_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
`ifdef IM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W:0]   idx_q, idx_d;     // one extra bit so idx can reach N = 2**ADDR_W
  logic [23:0]       word_q, word_d;   // first three bytes of the word in flight
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic            xfer;
  logic [15:0]     n_len;
  logic [ADDR_W:0] idx_inc;
  state_t          st_fin;           // where a complete (or empty) frame goes next

  assign xfer    = byte_valid && byte_ready;
  assign n_len   = {len_hi_q, byte_data};
  assign idx_inc = idx_q + 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
  assign st_fin  = S_CHK;
`else
  assign st_fin  = S_DONE;
`endif

  // Status and handshake outputs decode directly from the state register.
  always_comb begin
    byte_ready = 1'b0;
    unique case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA: byte_ready = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK:                      byte_ready = 1'b1;
`endif
      default:                    byte_ready = 1'b0;
    endcase
  end

  assign im_we    = (state_q == S_WRITE);
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign cpu_rst  = (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    n_d      = n_q;
    idx_d    = idx_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = byte_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d = n_len;
          if (n_len == 16'd0)                state_d = st_fin;
          else if ({1'b0, n_len} > MAX_N)    state_d = S_ERR;
          else                               state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[15:0], byte_data};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          // Fourth byte: latch the full word so the write happens next cycle.
          if (bcnt_q == 2'd3) begin
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = {word_q, byte_data};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (32'(idx_inc) == 32'(n_q)) state_d = st_fin;
        else                          state_d = S_DATA;
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_hi_q <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      bcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule
